commit_trace_unit: RTL and testbench
====================================

// Module: commit_trace_unit
// PURPOSE
//  Write-back side observer of pipelined_processor; sits downstream of the MEM/WB register.
//  - Captures every architectural register write into a trace FIFO.
//  - Keeps cycle, retire, stall and drop counters.
//  - Detects end of program (fetched instruction == 32'h0) and raises halted once the pipeline has drained.
//  - Replaces the bench-side halt/print logic with synthesizable hardware that a test or debug host drains.
// PARAMETERS
//  DEPTH         16  trace FIFO entries; power of 2, >=2
//  DRAIN_CYCLES   4  cycles from zero-fetch detection to halted (IF->WB depth)
//  CNT_W         32  width of each performance counter
// PORTS
//  clk              in   1      system clock, rising edge
//  reset            in   1      asynchronous, active-high reset
//  wb_reg_write_en  in   1      MEM/WB RegWrite
//  wb_rd            in   5      MEM/WB destination register
//  wb_data          in   32     final write-back value (post MemToReg mux)
//  wb_pc            in   32     PC of the writing instruction (used only with COMMIT_TRACE_PC_EN)
//  if_instr         in   32     instruction currently fetched
//  stall            in   1      hazard unit control_mux_sel (bubble inserted)
//  trace_ready      in   1      consumer accepts head entry
//  trace_valid      out  1      FIFO non-empty
//  trace_rd         out  5      head entry rd
//  trace_data       out  32     head entry data
//  trace_pc         out  32     head entry PC (tied 0 without COMMIT_TRACE_PC_EN)
//  level            out  $clog2(DEPTH)+1  current FIFO occupancy
//  cycle_count      out  CNT_W  cycles since reset, frozen in HALTED
//  retire_count     out  CNT_W  commits seen (accepted + dropped)
//  stall_count      out  CNT_W  cycles with stall=1 while not HALTED
//  drop_count       out  CNT_W  commits lost to a full FIFO
//  halted           out  1      program complete and pipeline drained
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; state RUN; drain counter 0.
//  - Commit: wb_reg_write_en=1 && wb_rd!=0 && state!=HALTED.
//    - Writes to x0 are ignored entirely: no push, no count.
//  - Push: the commit is written in the same edge; it is visible at the head 1 cycle later if the FIFO was empty.
//  - Pop: trace_valid && trace_ready at the rising edge.
//    - trace_* outputs are driven combinationally from the head entry.
//  - Full FIFO (level==DEPTH) with a commit:
//    - with no pop: entry dropped, drop_count+1;
//    - with a pop in the same cycle: push accepted, nothing dropped.
//  - Empty FIFO: trace_ready is ignored; level never underflows.
//  - Simultaneous push and pop: level unchanged.
//  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
//  - Counters saturate at all-ones and never wrap.
//    - retire_count increments on every commit, whether accepted or dropped.
//  - State machine:
//    - RUN:
//      - if_instr==0 -> DRAIN, with drain counter loaded to DRAIN_CYCLES-1.
//      - Not taken while reset is high, or in the first cycle after reset (fetch not yet valid).
//    - DRAIN:
//      - Commits are still captured; drain counter decrements.
//      - A nonzero if_instr does not abort DRAIN.
//      - Counter==0 -> HALTED.
//    - HALTED:
//      - halted=1 from the cycle after entry; cycle_count and stall_count frozen; commits ignored.
//      - The FIFO keeps draining normally.
//      - Exit only by reset.
//  - Reset asserted mid-operation: immediate return to RUN; FIFO contents and counters lost.
// CONFIGURATION
//  COMMIT_TRACE_PC_EN
//    - defined: each FIFO entry stores wb_pc (69-bit entry); trace_pc is the head PC.
//    - undefined: entries are 37 bits; wb_pc is unused; trace_pc is held 0.
// TESTING
//  1. Reset held, then released -> all counters 0, trace_valid=0, halted=0, level=0.
//  2. Commits x3=0x5, x0=0x9, x4=0xA on consecutive cycles, trace_ready=0 ->
//     level=2, retire_count=2; popping yields (3,0x5) then (4,0xA).
//  3. DEPTH=16, trace_ready=0, 18 commits -> level=16, drop_count=2, retire_count=18.
//     Then one commit together with one pop at full -> drop_count stays 2, level stays 16.
//  4. if_instr=0 at cycle N -> halted rises at cycle N+DRAIN_CYCLES+1.
//     A commit at cycle N+2 is captured; a commit after halted is ignored; cycle_count stops changing.
//  5. stall=1 for 3 cycles -> stall_count=3; reset pulse in DRAIN -> state RUN, counters 0, FIFO empty.
//  6. COMMIT_TRACE_PC_EN defined, commit with wb_pc=0x40 -> trace_pc=0x40 at head.
//     Macro undefined -> trace_pc=0.

Source files
------------

// File: rtl/commit_trace_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : commit_trace_unit                                            |
// | Description : Write-back observer. Captures register commits into a trace  |
// |               FIFO, keeps saturating performance counters and raises       |
// |               halted once a zero fetch has drained through the pipeline.   |
// | Config      : COMMIT_TRACE_PC_EN - store wb_pc with each trace entry       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module commit_trace_unit #(
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_reg_write_en,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_data,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                if_instr,
  input  logic                       stall,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [4:0]                 trace_rd,
  output logic [31:0]                trace_data,
  output logic [31:0]                trace_pc,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           retire_count,
  output logic [CNT_W-1:0]           stall_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       halted
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [c_LW-1:0] c_FULL       = c_LW'(DEPTH);
  localparam logic [c_DW-1:0] c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES - 1);

`ifdef COMMIT_TRACE_PC_EN
  localparam int c_EW = 69;
`else
  localparam int c_EW = 37;
`endif

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_DW-1:0]   r_drain_cnt;
  logic [c_DW-1:0]   w_drain_nxt;
  logic              r_started;

  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_LW-1:0]   r_level;

  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_not_halted;
  logic              w_commit;
  logic              w_full;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [c_EW-1:0]   w_entry_in;
  logic [c_EW-1:0]   w_head;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign w_not_halted = (r_state != ST_HALTED);
  assign w_commit     = wb_reg_write_en && (wb_rd != 5'd0) && w_not_halted;
  assign w_full       = (r_level == c_FULL);
  assign w_valid      = (r_level != '0);
  assign w_pop        = w_valid && trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push       = w_commit && (!w_full || w_pop);
  assign w_drop       = w_commit && w_full && !w_pop;
  assign w_head       = r_mem[r_rd_ptr];

`ifdef COMMIT_TRACE_PC_EN
  assign w_entry_in = {wb_pc, wb_rd, wb_data};
  assign trace_pc   = w_valid ? w_head[68:37] : 32'h0;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^wb_pc;
  assign w_entry_in  = {wb_rd, wb_data};
  assign trace_pc    = 32'h0;
`endif

  // Head entry is presented combinationally; zeroed when the FIFO is empty.
  assign trace_valid  = w_valid;
  assign trace_rd     = w_valid ? w_head[36:32] : 5'd0;
  assign trace_data   = w_valid ? w_head[31:0]  : 32'h0;
  assign level        = r_level;
  assign cycle_count  = r_cycle_cnt;
  assign retire_count = r_retire_cnt;
  assign stall_count  = r_stall_cnt;
  assign drop_count   = r_drop_cnt;
  assign halted       = (r_state == ST_HALTED);

  // Trace storage: write-only on accepted commits, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at DEPTH naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Performance counters; cycle and stall counts freeze once halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_not_halted)          r_cycle_cnt  <= sat_inc(r_cycle_cnt);
      if (w_commit)              r_retire_cnt <= sat_inc(r_retire_cnt);
      if (stall && w_not_halted) r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (w_drop)                r_drop_cnt   <= sat_inc(r_drop_cnt);
    end
  end

  // State register plus a flag that masks the first, not-yet-valid fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_started   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_started   <= 1'b1;
    end
  end

  // Next-state: a zero fetch starts a fixed drain, after which we halt for good.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (r_started && (if_instr == 32'h0)) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = c_DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = ST_HALTED;
        else                   w_drain_nxt = r_drain_cnt - 1'b1;
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_commit_trace_unit                                         |
// | Description : Directed self-checking bench for commit_trace_unit           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_commit_trace_unit;

  logic        clk;
  logic        reset;
  logic        wb_reg_write_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] if_instr;
  logic        stall;
  logic        trace_ready;
  logic        trace_valid;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [31:0] trace_pc;
  logic [4:0]  level;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic [31:0] stall_count;
  logic [31:0] drop_count;
  logic        halted;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int frozen;
  logic [31:0] exp_pc;

  commit_trace_unit #(.DEPTH(16), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .wb_reg_write_en(wb_reg_write_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .if_instr(if_instr), .stall(stall), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data),
    .trace_pc(trace_pc), .level(level), .cycle_count(cycle_count),
    .retire_count(retire_count), .stall_count(stall_count),
    .drop_count(drop_count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wb_reg_write_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    wb_pc = 32'h0; if_instr = 32'h0; stall = 1'b0; trace_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with a zero fetch present the whole time
    check("rst_valid",  {31'd0, trace_valid}, 32'd0);
    check("rst_level",  {27'd0, level}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cycle",  cycle_count, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_drop",   drop_count, 32'd0);
    check("rst_stall",  stall_count, 32'd0);
    check("rst_trpc",   trace_pc, 32'd0);
    reset = 1'b0; ecnt = 0;
    // First edge after reset: zero fetch must be ignored
    tick();
    if_instr = 32'h13;
    repeat (5) tick();
    check("first_fetch_ignored", {31'd0, halted}, 32'd0);
    check("cycle_run", cycle_count, ecnt);

    // Commits x3, x0 (ignored), x4
    wb_reg_write_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h5; wb_pc = 32'h40;
    tick();
    wb_rd = 5'd0; wb_data = 32'h9; wb_pc = 32'h44;
    tick();
    wb_rd = 5'd4; wb_data = 32'hA; wb_pc = 32'h48;
    tick();
    wb_reg_write_en = 1'b0;
`ifdef COMMIT_TRACE_PC_EN
    exp_pc = 32'h40;
`else
    exp_pc = 32'h0;
`endif
    check("c2_level",  {27'd0, level}, 32'd2);
    check("c2_retire", retire_count, 32'd2);
    check("c2_valid",  {31'd0, trace_valid}, 32'd1);
    check("c2_rd0",    {27'd0, trace_rd}, 32'd3);
    check("c2_data0",  trace_data, 32'h5);
    check("c2_pc0",    trace_pc, exp_pc);
    trace_ready = 1'b1;
    tick();
    check("c2_rd1",    {27'd0, trace_rd}, 32'd4);
    check("c2_data1",  trace_data, 32'hA);
    check("c2_level1", {27'd0, level}, 32'd1);
    tick();
    check("c2_empty",  {31'd0, trace_valid}, 32'd0);
    check("c2_rd_emp", {27'd0, trace_rd}, 32'd0);
    trace_ready = 1'b0;

    // Overfill: 18 commits into 16 slots
    wb_reg_write_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wb_rd = 5'(1 + (i % 31)); wb_data = i;
      tick();
    end
    wb_reg_write_en = 1'b0;
    check("full_level",  {27'd0, level}, 32'd16);
    check("full_drop",   drop_count, 32'd2);
    check("full_retire", retire_count, 32'd20);
    check("full_head",   trace_data, 32'd0);
    // Commit plus pop at full: accepted, nothing dropped
    wb_reg_write_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h100; trace_ready = 1'b1;
    tick();
    wb_reg_write_en = 1'b0; trace_ready = 1'b0;
    check("fp_drop",   drop_count, 32'd2);
    check("fp_level",  {27'd0, level}, 32'd16);
    check("fp_retire", retire_count, 32'd21);
    check("fp_head",   trace_data, 32'd1);
    trace_ready = 1'b1;
    repeat (15) tick();
    check("wrap_level", {27'd0, level}, 32'd1);
    check("wrap_data",  trace_data, 32'h100);
    check("wrap_rd",    {27'd0, trace_rd}, 32'd7);
    tick();
    check("drain_level", {27'd0, level}, 32'd0);
    tick();
    check("underflow_level", {27'd0, level}, 32'd0);
    check("underflow_valid", {31'd0, trace_valid}, 32'd0);
    trace_ready = 1'b0;

    // Stall counting
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    check("stall_cnt", stall_count, 32'd3);
    check("cycle_mid", cycle_count, ecnt);

    // Zero fetch -> drain -> halt
    if_instr = 32'h0;
    tick();
    if_instr = 32'h13;
    tick();
    wb_reg_write_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hBEEF;
    tick();
    wb_reg_write_en = 1'b0;
    tick();
    check("halt_early", {31'd0, halted}, 32'd0);
    tick();
    check("halt_rise",  {31'd0, halted}, 32'd1);
    frozen = ecnt;
    check("halt_cycle", cycle_count, frozen);
    check("drain_cap_level",  {27'd0, level}, 32'd1);
    check("drain_cap_retire", retire_count, 32'd22);
    wb_reg_write_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h55; stall = 1'b1;
    tick();
    wb_reg_write_en = 1'b0; stall = 1'b0;
    check("hlt_retire", retire_count, 32'd22);
    check("hlt_level",  {27'd0, level}, 32'd1);
    check("hlt_stall",  stall_count, 32'd3);
    check("hlt_cycle1", cycle_count, frozen);
    tick();
    check("hlt_cycle2", cycle_count, frozen);
    check("hlt_rd",     {27'd0, trace_rd}, 32'd9);
    check("hlt_data",   trace_data, 32'hBEEF);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    check("hlt_pop_level", {27'd0, level}, 32'd0);
    check("hlt_stays",     {31'd0, halted}, 32'd1);

    // Reset pulse in DRAIN
    reset = 1'b1;
    #2;
    reset = 1'b0; ecnt = 0;
    repeat (2) tick();
    if_instr = 32'h0;
    tick();
    if_instr = 32'h13;
    wb_reg_write_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
    tick();
    wb_reg_write_en = 1'b0;
    check("pre_rst_level", {27'd0, level}, 32'd1);
    reset = 1'b1;
    #2;
    check("mid_rst_level",  {27'd0, level}, 32'd0);
    check("mid_rst_valid",  {31'd0, trace_valid}, 32'd0);
    check("mid_rst_retire", retire_count, 32'd0);
    check("mid_rst_cycle",  cycle_count, 32'd0);
    reset = 1'b0; ecnt = 0;
    repeat (6) tick();
    check("post_rst_run",   {31'd0, halted}, 32'd0);
    check("post_rst_cycle", cycle_count, ecnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
